driver_ctrl: RTL

- Sequencer for the driver master-read datapath; fetches a block of test vectors from memory, one VEC_DWORDS-dword vector at a time.
- Per dword: issues a single-cycle read strobe with its address, waits for returned data, captures it.
- After the last dword of a vector, presents the assembled vector to the downstream stimulus driver with a valid/ready handshake.
- Sits between test control (start/done) and the master read port.

---
 rtl/driver_ctrl_if.sv | 32 +++
 rtl/driver_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/driver_ctrl_if.sv
// rtl/driver_ctrl_if.sv - master read port and vector handshake bundle for driver_ctrl
interface driver_ctrl_if #(
    parameter int unsigned VEC_DWORDS = 3
) ();
    logic                      master_rd;
    logic [31:0]               master_addr;
    logic [31:0]               master_data_in;
    logic                      master_data_in_val;
    logic [32*VEC_DWORDS-1:0]  vector_data;
    logic                      vector_valid;
    logic                      vector_ready;

    modport master (
        output master_rd,
        output master_addr,
        output vector_data,
        output vector_valid,
        input  master_data_in,
        input  master_data_in_val,
        input  vector_ready
    );

    modport slave (
        input  master_rd,
        input  master_addr,
        input  vector_data,
        input  vector_valid,
        output master_data_in,
        output master_data_in_val,
        output vector_ready
    );
endinterface

// File: rtl/driver_ctrl.sv
// rtl/driver_ctrl.sv - test vector fetch sequencer for the driver master-read datapath
module driver_ctrl #(
    parameter int unsigned VEC_DWORDS     = 3,
    parameter int unsigned DWORD_BYTES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [31:0]        base_addr,
    input  logic [15:0]        num_vectors,
    driver_ctrl_if.master      bus,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [15:0]        vec_count
);
    localparam int unsigned VW = 32 * VEC_DWORDS;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PRESENT, FINISH} state_t;

    state_t          state, state_nxt;
    logic [31:0]     cur_addr, cur_addr_nxt;
    logic [15:0]     nvec, nvec_nxt;
    logic [2:0]      k, k_nxt;
    logic [15:0]     tcnt, tcnt_nxt;
    logic            rd_q, rd_nxt;
    logic [31:0]     maddr_q, maddr_nxt;
    logic [VW-1:0]   vdata_q, vdata_nxt;
    logic            vvalid_q, vvalid_nxt;
    logic            busy_nxt, done_nxt, error_nxt;
    logic [15:0]     vcnt_nxt;

    assign bus.master_rd    = rd_q;
    assign bus.master_addr  = maddr_q;
    assign bus.vector_data  = vdata_q;
    assign bus.vector_valid = vvalid_q;

    // State and every output are registered; reset aborts a run without a done pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cur_addr  <= '0;
            nvec      <= '0;
            k         <= '0;
            tcnt      <= '0;
            rd_q      <= 1'b0;
            maddr_q   <= '0;
            vdata_q   <= '0;
            vvalid_q  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            vec_count <= '0;
        end else begin
            state     <= state_nxt;
            cur_addr  <= cur_addr_nxt;
            nvec      <= nvec_nxt;
            k         <= k_nxt;
            tcnt      <= tcnt_nxt;
            rd_q      <= rd_nxt;
            maddr_q   <= maddr_nxt;
            vdata_q   <= vdata_nxt;
            vvalid_q  <= vvalid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            error     <= error_nxt;
            vec_count <= vcnt_nxt;
        end
    end

    // Next state plus next register values; outputs for a state are set on entry to it
    always_comb begin
        state_nxt    = state;
        cur_addr_nxt = cur_addr;
        nvec_nxt     = nvec;
        k_nxt        = k;
        tcnt_nxt     = tcnt;
        rd_nxt       = 1'b0;
        maddr_nxt    = maddr_q;
        vdata_nxt    = vdata_q;
        vvalid_nxt   = vvalid_q;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        error_nxt    = error;
        vcnt_nxt     = vec_count;

        case (state)
            IDLE: begin
                if (start) begin
                    error_nxt = 1'b0;
                    vcnt_nxt  = '0;
                    busy_nxt  = 1'b1;
                    if (num_vectors != 16'd0) begin
                        nvec_nxt     = num_vectors;
                        cur_addr_nxt = base_addr;
                        k_nxt        = '0;
                        state_nxt    = ISSUE;
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = FINISH;
                    end
                end
            end
            ISSUE: begin
                rd_nxt    = 1'b1;
                maddr_nxt = cur_addr;
                tcnt_nxt  = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.master_data_in_val) begin
                    for (int i = 0; i < int'(VEC_DWORDS); i++) begin
                        if (k == 3'(i)) begin
                            vdata_nxt[i*32 +: 32] = bus.master_data_in;
                        end
                    end
                    cur_addr_nxt = cur_addr + 32'(DWORD_BYTES);
                    if (k == 3'(VEC_DWORDS - 1)) begin
                        k_nxt      = '0;
                        vvalid_nxt = 1'b1;
                        state_nxt  = PRESENT;
                    end else begin
                        k_nxt     = k + 3'd1;
                        state_nxt = ISSUE;
                    end
                end else if (tcnt == 16'(TIMEOUT_CYCLES - 1)) begin
                    error_nxt = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = FINISH;
                end else begin
                    tcnt_nxt = tcnt + 16'd1;
                end
            end
            PRESENT: begin
                if (bus.vector_ready) begin
                    vvalid_nxt = 1'b0;
                    vcnt_nxt   = vec_count + 16'd1;
                    if (vec_count + 16'd1 == nvec) begin
                        done_nxt  = 1'b1;
                        state_nxt = FINISH;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            FINISH: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule
